nes_controller_port: RTL

Standard NES controller port at CPU $4016/$4017, fed by the 8-bit USB keycode from the SoC. It decodes the keycode into the 8-bit NES button set and holds each press across USB polling gaps. It implements the strobe latch and serial shift register that the CPU reads one bit at a time. It sits on the CPU bus inside the NES architecture, beside the APU/IO register decode.

---
 rtl/nes_controller_port.sv | 108 ++++++++++
 1 files changed

// File: rtl/nes_controller_port.sv
// NES controller port at $4016/$4017: USB keycode decode with release hold, strobe latch
// and the serial shift register the CPU reads one bit at a time.
module nes_controller_port #(
    parameter int unsigned HOLD_CYCLES = 1000000,
    parameter logic [15:0] PORT1_ADDR  = 16'h4016,
    parameter logic [15:0] PORT2_ADDR  = 16'h4017
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        cpu_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw_n,
    input  logic [7:0]  keycode,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_valid,
    output logic [7:0]  buttons
);

    localparam int unsigned CntW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);

    logic [7:0]      decoded;
    logic [7:0]      held_q, held_d;
    logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
    logic            strobe_q, strobe_d;
    logic [7:0]      shift_q, shift_d;
    logic            sel_p1, sel_p2;
    logic            p1_wr, p1_rd;

    // Only bit 0 of the strobe write matters.
    logic unused_wdata;
    assign unused_wdata = ^cpu_wdata[7:1];

    always_comb begin
        decoded = 8'h00;
        case (keycode)
            8'h0E:   decoded = 8'h01;
            8'h0D:   decoded = 8'h02;
            8'h2C:   decoded = 8'h04;
            8'h28:   decoded = 8'h08;
            8'h1A:   decoded = 8'h10;
            8'h16:   decoded = 8'h20;
            8'h04:   decoded = 8'h40;
            8'h07:   decoded = 8'h80;
            default: decoded = 8'h00;
        endcase
    end

    always_comb begin
        held_d     = held_q;
        hold_cnt_d = hold_cnt_q;
        if (decoded != 8'h00) begin
            held_d     = decoded;
            hold_cnt_d = CntLoad;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 1'b1;
        end else begin
            held_d = 8'h00;
        end
    end

    assign sel_p1 = (cpu_addr == PORT1_ADDR);
    assign sel_p2 = (cpu_addr == PORT2_ADDR);
    assign p1_wr  = cpu_en && !cpu_rw_n && sel_p1;
    assign p1_rd  = cpu_en && cpu_rw_n && sel_p1;

    // While strobe is high the register tracks held every cycle, which also covers the
    // 1->0 write edge; reads only shift once strobe is low.
    always_comb begin
        strobe_d = p1_wr ? cpu_wdata[0] : strobe_q;
        shift_d  = shift_q;
        if (strobe_q) begin
            shift_d = held_q;
        end else if (p1_rd) begin
            shift_d = {1'b1, shift_q[7:1]};
        end
    end

    always_comb begin
        cpu_rdata       = 8'h00;
        cpu_rdata_valid = 1'b0;
        if (cpu_rw_n && sel_p1) begin
            cpu_rdata       = {7'b0100000, strobe_q ? held_q[0] : shift_q[0]};
            cpu_rdata_valid = 1'b1;
        end else if (cpu_rw_n && sel_p2) begin
            cpu_rdata       = 8'h40;
            cpu_rdata_valid = 1'b1;
        end
    end

    assign buttons = held_q;

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            strobe_q   <= 1'b0;
            shift_q    <= 8'hFF;
            held_q     <= 8'h00;
            hold_cnt_q <= '0;
        end else begin
            strobe_q   <= strobe_d;
            shift_q    <= shift_d;
            held_q     <= held_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule
